// File: rtl/ram_wr_arb_if.sv
// Write-request bus between requesters and the RAM write arbiter, plus the
// RAM write port and init control/status.
interface ram_wr_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 8,
    parameter int NUM_REQ    = 2
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic                          i_init_start;
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*AW-1:0]         i_req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          o_ram_wr_en;
    logic [AW-1:0]                 o_ram_wr_addr;
    logic [DATA_WIDTH-1:0]         o_ram_data_in;
    logic                          o_init_done;

    modport slave (
        input  i_init_start, i_req_valid, i_req_addr, i_req_data,
        output o_req_ready, o_ram_wr_en, o_ram_wr_addr, o_ram_data_in, o_init_done
    );

    modport master (
        output i_init_start, i_req_valid, i_req_addr, i_req_data,
        input  o_req_ready, o_ram_wr_en, o_ram_wr_addr, o_ram_data_in, o_init_done
    );
endinterface

// File: rtl/ram_wr_arb.sv
// Round-robin write arbiter for a single-port RAM; clears every word to
// INIT_VALUE after reset or on request before accepting requester writes.
module ram_wr_arb #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 8,
    parameter int                    NUM_REQ    = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic         clk,
    input  logic         n_rst,
    ram_wr_arb_if.slave  bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][AW-1:0]         req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;

    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx;
    logic [NUM_REQ-1:0]    rdy;
    logic                  wen;
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  done;

    assign req_valid = bus.i_req_valid;
    assign req_addr  = bus.i_req_addr;
    assign req_data  = bus.i_req_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PW-1:0] j;
        j       = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!gnt_vld && req_valid[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = j;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rdy     = '0;
        wen     = 1'b0;
        waddr   = '0;
        wdata   = '0;
        done    = 1'b0;
        case (state_q)
            S_INIT: begin
                wen   = 1'b1;
                waddr = cnt_q;
                wdata = INIT_VALUE;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                done = 1'b1;
                if (gnt_vld) begin
                    rdy[gnt_idx] = 1'b1;
                    wen          = 1'b1;
                    waddr        = req_addr[gnt_idx];
                    wdata        = req_data[gnt_idx];
                    ptr_d        = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                end
                // init_start only steers the next state, never an output.
                if (bus.i_init_start) state_d = S_INIT;
            end
        endcase
        // The INIT state is forced during reset, so outputs are masked here.
        if (!n_rst) begin
            rdy   = '0;
            wen   = 1'b0;
            waddr = '0;
            wdata = '0;
            done  = 1'b0;
        end
    end

    assign bus.o_req_ready   = rdy;
    assign bus.o_ram_wr_en   = wen;
    assign bus.o_ram_wr_addr = waddr;
    assign bus.o_ram_data_in = wdata;
    assign bus.o_init_done   = done;
endmodule

// File: tb/tb_ram_wr_arb.sv
// Bench for ram_wr_arb: table-driven RUN vectors plus hand sequences for
// init, init-during-traffic, ignored start and reset mid-INIT.
module tb_ram_wr_arb;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int NR    = 2;
    localparam int AW    = 3;
    localparam logic [DW-1:0] INIT = 8'h5C;

    typedef struct packed {
        logic [NR-1:0] rdy;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    typedef struct {
        logic             st;
        logic [NR-1:0]    v;
        logic [NR*AW-1:0] a;
        logic [NR*DW-1:0] d;
        exp_t             e;
    } vec_t;

    logic clk;
    logic n_rst;
    int   nvec = 0;
    int   nerr = 0;

    exp_t    exp_q[$];
    string   nm_q[$];
    exp_t    act;
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] exp_ram [DEPTH];
    vec_t    tbl [11];

    ram_wr_arb_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_REQ(NR)) bus ();

    ram_wr_arb #(
        .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_REQ(NR), .INIT_VALUE(INIT)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Paired RAM: synchronous write port driven by the arbiter.
    always @(posedge clk)
        if (bus.o_ram_wr_en) ram[bus.o_ram_wr_addr] <= bus.o_ram_data_in;

    assign act = {bus.o_req_ready, bus.o_ram_wr_en, bus.o_ram_wr_addr,
                  bus.o_ram_data_in, bus.o_init_done};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            nvec++;
            if (act !== e) begin
                nerr++;
                $display("FAIL %s: got rdy=%b wen=%b addr=%0d data=%h done=%b, want rdy=%b wen=%b addr=%0d data=%h done=%b",
                         nm, act.rdy, act.wen, act.addr, act.data, act.done,
                         e.rdy, e.wen, e.addr, e.data, e.done);
            end
        end
    end

    function automatic exp_t mk(input logic [1:0] rdy, input logic wen,
                                input logic [2:0] addr, input logic [7:0] data,
                                input logic done);
        mk = {rdy, wen, addr, data, done};
    endfunction

    // Entered just after a posedge; returns just after the next posedge.
    task automatic cyc(input logic st, input logic [1:0] v, input logic [5:0] a,
                       input logic [15:0] d, input exp_t e, input string nm);
        bus.i_init_start = st;
        bus.i_req_valid  = v;
        bus.i_req_addr   = a;
        bus.i_req_data   = d;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq(input logic [7:0] st_mask, input logic [1:0] v,
                            input logic [5:0] a, input logic [15:0] d);
        for (int i = 0; i < DEPTH; i++)
            cyc(st_mask[i], v, a, d, mk(2'b00, 1'b1, 3'(i), INIT, 1'b0),
                $sformatf("init%0d", i));
    endtask

    task automatic ram_chk(input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            nvec++;
            if (ram[i] !== exp_ram[i]) begin
                nerr++;
                $display("FAIL %s ram[%0d]: got %h want %h", nm, i, ram[i], exp_ram[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 2'b00, 6'o00, 16'h0000, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b1)};
        tbl[1]  = '{1'b0, 2'b01, 6'o03, 16'h00A5, mk(2'b01, 1'b1, 3'd3, 8'hA5, 1'b1)};
        tbl[2]  = '{1'b0, 2'b00, 6'o03, 16'h00A5, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b1)};
        tbl[3]  = '{1'b0, 2'b01, 6'o05, 16'h0011, mk(2'b01, 1'b1, 3'd5, 8'h11, 1'b1)};
        tbl[4]  = '{1'b0, 2'b10, 6'o60, 16'h2200, mk(2'b10, 1'b1, 3'd6, 8'h22, 1'b1)};
        tbl[5]  = '{1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b01, 1'b1, 3'd1, 8'h33, 1'b1)};
        tbl[6]  = '{1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b10, 1'b1, 3'd2, 8'h44, 1'b1)};
        tbl[7]  = '{1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b01, 1'b1, 3'd1, 8'h33, 1'b1)};
        tbl[8]  = '{1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b10, 1'b1, 3'd2, 8'h44, 1'b1)};
        tbl[9]  = '{1'b0, 2'b11, 6'o07, 16'h0FFF, mk(2'b01, 1'b1, 3'd7, 8'hFF, 1'b1)};
        tbl[10] = '{1'b0, 2'b10, 6'o07, 16'h0FFF, mk(2'b10, 1'b1, 3'd0, 8'h0F, 1'b1)};

        n_rst = 1'b0;
        bus.i_init_start = 1'b0;
        bus.i_req_valid  = '0;
        bus.i_req_addr   = '0;
        bus.i_req_data   = '0;
        @(posedge clk);
        #1;

        // Reset held: everything quiet even with requests pending.
        cyc(1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b0), "rst0");
        cyc(1'b1, 2'b11, 6'o21, 16'h4433, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b0), "rst1");

        // Release: 8-cycle clear; init_start pulses in INIT are ignored.
        n_rst = 1'b1;
        init_seq(8'b1000_1000, 2'b11, 6'o21, 16'h4433);
        for (int i = 0; i < DEPTH; i++) exp_ram[i] = INIT;
        ram_chk("clear");

        for (int i = 0; i < 11; i++)
            cyc(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("tbl%0d", i));
        exp_ram[3] = 8'hA5; exp_ram[5] = 8'h11; exp_ram[6] = 8'h22;
        exp_ram[1] = 8'h33; exp_ram[2] = 8'h44; exp_ram[7] = 8'hFF;
        exp_ram[0] = 8'h0F;
        ram_chk("run");

        // init_start while requester 1 is granted: its write still lands.
        cyc(1'b1, 2'b10, 6'o40, 16'h6600, mk(2'b10, 1'b1, 3'd4, 8'h66, 1'b1), "init_gnt");
        nvec++;
        if (ram[4] !== 8'h66) begin
            nerr++;
            $display("FAIL init_gnt_commit: got %h want 66", ram[4]);
        end
        init_seq(8'b0000_0000, 2'b11, 6'o21, 16'h4433);
        cyc(1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b01, 1'b1, 3'd1, 8'h33, 1'b1), "resume");
        for (int i = 0; i < DEPTH; i++) exp_ram[i] = INIT;
        exp_ram[1] = 8'h33;
        ram_chk("reinit");

        // ptr is now 1. Restart init, then reset at cnt=4.
        cyc(1'b1, 2'b00, 6'o00, 16'h0000, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b1), "restart");
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 2'b00, 6'o00, 16'h0000, mk(2'b00, 1'b1, 3'(i), INIT, 1'b0),
                $sformatf("part%0d", i));
        n_rst = 1'b0;
        cyc(1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b0), "midrst0");
        cyc(1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b0), "midrst1");
        n_rst = 1'b1;
        init_seq(8'b0000_0000, 2'b11, 6'o21, 16'h4433);
        // ptr back to 0 after reset, so requester 0 wins.
        cyc(1'b0, 2'b11, 6'o21, 16'h4433, mk(2'b01, 1'b1, 3'd1, 8'h33, 1'b1), "post_rst");
        cyc(1'b0, 2'b00, 6'o00, 16'h0000, mk(2'b00, 1'b0, 3'd0, 8'h00, 1'b1), "idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ram_wr_arb.md
RAM_WR_ARB -- requirements
Module: ram_wr_arb

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 8, the write data width.
REQ-002 SHALL take parameter RAM_DEPTH, default 8, the number of RAM words (AW = $clog2(RAM_DEPTH)).
REQ-003 SHALL take parameter NUM_REQ, default 2, the number of write requesters (legal range 2..8).
REQ-004 SHALL take parameter INIT_VALUE, default 0, a DATA_WIDTH-bit value written to every word during initialisation.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is on posedge.
REQ-006 SHALL have port n_rst, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port i_init_start, input, 1, a request to re-run initialisation.
REQ-008 SHALL have port i_req_valid, input, NUM_REQ, the per-requester write-valid.
REQ-009 SHALL have port i_req_addr, input, NUM_REQ*AW, the packed addresses; requester k occupies bits [k*AW +: AW].
REQ-010 SHALL have port i_req_data, input, NUM_REQ*DATA_WIDTH, the packed data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port o_req_ready, output, NUM_REQ, the per-requester accept signal.
REQ-012 SHALL have port o_ram_wr_en, output, 1, driving the RAM synchronous write enable.
REQ-013 SHALL have port o_ram_wr_addr, output, AW, driving the RAM write address.
REQ-014 SHALL have port o_ram_data_in, output, DATA_WIDTH, driving the RAM write data.
REQ-015 SHALL have port o_init_done, output, 1, high once RAM contents are valid for reading.

Function
REQ-016 SHALL implement a two-state FSM: INIT and RUN.
REQ-017 SHALL keep an AW-bit clear counter, cnt.
- In INIT: o_ram_wr_en=1, o_ram_wr_addr=cnt, o_ram_data_in=INIT_VALUE, o_req_ready=0, o_init_done=0.
- cnt increments each cycle.
- INIT lasts exactly RAM_DEPTH cycles.
REQ-018 SHALL transition INIT->RUN on the edge where cnt==RAM_DEPTH-1, and clear cnt to 0 on that edge.
REQ-019 SHALL transition RUN->INIT on the edge where i_init_start=1 while in RUN.
- If a requester is granted in that same cycle, that grant still completes its handshake.
- i_init_start SHALL be ignored while in INIT; initialisation does not restart.
REQ-020 SHALL drive o_init_done=1 in RUN only.
REQ-021 SHALL arbitrate in RUN using round-robin with a priority pointer ptr (width $clog2(NUM_REQ), reset 0).
- The grant goes to the first k, searching ptr, ptr+1, ... modulo NUM_REQ, with i_req_valid[k]=1.
REQ-022 SHALL assert at most one o_req_ready bit per cycle, combinationally, only for the granted k.
- o_req_ready SHALL be all-zero when no valid is set.
REQ-023 SHALL treat a handshake as accepted when i_req_valid[k] & o_req_ready[k].
- On acceptance: o_ram_wr_en=1, o_ram_wr_addr=i_req_addr[k], o_ram_data_in=i_req_data[k], all in the same cycle.
- The write commits at that clock edge, giving zero-cycle latency.
REQ-024 SHALL update ptr to (k+1) mod NUM_REQ on acceptance and hold ptr otherwise.
REQ-025 SHALL drive o_ram_wr_en=0, o_ram_wr_addr=0 and o_ram_data_in=0 in RUN with no valid.
REQ-026 SHALL forward addresses unchanged, performing no range checking.
REQ-027 SHALL make no ordering guarantee between simultaneous requesters to the same address beyond the grant order.
REQ-028 SHALL hold a requester's valid, address and data stable until acceptance (requester obligation).
- The arbiter SHALL NOT drop a pending valid.
- Round-robin SHALL bound wait to NUM_REQ-1 grants.
REQ-029 SHALL contain no combinational path from i_init_start to any output.

Reset
REQ-030 SHALL, while n_rst=0, asynchronously force state=INIT, cnt=0, ptr=0.
- While n_rst=0, outputs SHALL be o_req_ready=0, o_init_done=0, o_ram_wr_en=0, o_ram_wr_addr=0, o_ram_data_in=0.
REQ-031 SHALL begin INIT clearing from address 0 on the first posedge after n_rst deasserts.
REQ-032 SHALL, when reset asserts mid-INIT or mid-RUN, abandon all progress and restart full initialisation after release.

Verification
REQ-033 SHALL be verified by a reset-release clear (DEPTH=8): release n_rst.
- o_ram_wr_en=1 with addr 0..7 over 8 cycles, data=INIT_VALUE.
- o_init_done rises cycle 9; the paired RAM reads INIT_VALUE at all addresses.
REQ-034 SHALL be verified by a single requester: in RUN, valid[0]=1, addr=3, data=0xA5.
- o_req_ready=01 and o_ram_wr_en=1 in the same cycle.
- The RAM reads 0xA5 at addr 3 on the next cycle.
REQ-035 SHALL be verified by round-robin fairness: both valids held high for 4 cycles.
- Grants alternate 0,1,0,1; exactly one ready bit per cycle.
REQ-036 SHALL be verified by init during traffic: pulse i_init_start while valid[1] is granted.
- Req1's write commits, then 8 INIT writes with ready=00 and o_init_done=0, then RUN resumes.
REQ-037 SHALL be verified by reset mid-INIT: assert n_rst at cnt=4.
- All outputs go 0 immediately; after release, clearing restarts at addr 0 and takes a full 8 cycles.
REQ-038 SHALL be verified by ignored start: pulse i_init_start during INIT.
- INIT length stays exactly 8 cycles.
